bus_wait_model: RTL and testbench

Parametrised, synthesizable wait-state injector placed between a `naive_mips` bus master port (ibus or dbus) and a zero-latency memory such as `prog_rom` or `mem`. It holds the master in stall for a fixed or pseudo-random number of cycles and issues exactly one slave access per transaction. It registers the read data and flags protocol violations. One instance per bus; it replaces ad-hoc behavioural wait loops in benches and runs unchanged on FPGA.

---
 rtl/bus_wait_pkg.sv | 18 +
 rtl/bus_wait_lfsr.sv | 29 ++
 rtl/bus_wait_model.sv | 182 ++++++++++++++++++
 tb/tb_bus_wait_model.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_wait_pkg.sv
// Shared types and constants for the bus wait-state injector.
package bus_wait_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] MODE_FIXED  = 2'd0;
  localparam logic [1:0] MODE_RANDOM = 2'd1;
  localparam logic [1:0] MODE_BYPASS = 2'd2;

  // Fibonacci taps 16, 14, 13, 11 expressed as bit positions 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/bus_wait_lfsr.sv
// 16-bit Fibonacci LFSR; advances only when step is high, resets to SEED.
module bus_wait_lfsr
  import bus_wait_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [OUT_W-1:0] value
);

  logic [15:0] lfsr_r;

  // Shift register with XOR feedback of the tapped bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
    end else if (step) begin
      lfsr_r <= {lfsr_r[14:0], ^(lfsr_r & LFSR_TAPS)};
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign value = lfsr_r[OUT_W-1:0];

endmodule

// File: rtl/bus_wait_model.sv
// Wait-state injector between a bus master and a zero-latency memory:
// stalls the master W cycles, issues one slave strobe, flags protocol errors.
module bus_wait_model
  import bus_wait_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          WAIT_W    = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   m_address,
  input  logic [DATA_W/8-1:0] m_byteenable,
  input  logic                m_read,
  input  logic                m_write,
  input  logic [DATA_W-1:0]   m_wrdata,
  output logic [DATA_W-1:0]   m_rddata,
  output logic                m_stall,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W/8-1:0] s_byteenable,
  output logic [DATA_W-1:0]   s_wrdata,
  output logic                s_read,
  output logic                s_write,
  input  logic [DATA_W-1:0]   s_rddata,
  input  logic [1:0]          cfg_mode,
  input  logic [WAIT_W-1:0]   cfg_wait,
  output logic                proto_err,
  output logic [31:0]         txn_count
);

  localparam int BE_W = DATA_W / 8;

  state_t              state;
  logic [WAIT_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [BE_W-1:0]     be_r;
  logic [DATA_W-1:0]   wrdata_r;
  logic                write_r;
  logic [DATA_W-1:0]   rddata_r;
  logic                proto_err_r;
  logic [31:0]         txn_r;

  logic                req_s;
  logic                both_s;
  logic                bypass_s;
  logic                start_s;
  logic                viol_s;
  logic [WAIT_W-1:0]   lfsr_low_s;
  logic [WAIT_W-1:0]   wait_load_s;

  assign req_s    = m_read | m_write;
  assign both_s   = m_read & m_write;
  assign bypass_s = (state == ST_IDLE) && (cfg_mode == MODE_BYPASS);
  assign start_s  = (state == ST_IDLE) && req_s && !both_s && !bypass_s;

  bus_wait_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (WAIT_W)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (start_s),
    .value (lfsr_low_s)
  );

  // Wait count for a new transaction; reserved mode behaves as fixed.
  always_comb begin
    wait_load_s = cfg_wait;
    case (cfg_mode)
      MODE_RANDOM: wait_load_s = (lfsr_low_s < cfg_wait) ? lfsr_low_s : cfg_wait;
      MODE_FIXED:  wait_load_s = cfg_wait;
      default:     wait_load_s = cfg_wait;
    endcase
  end

  // A busy transaction must keep its request stable; read+write is illegal anywhere.
  always_comb begin
    viol_s = both_s;
    case (state)
      ST_WAIT, ST_ACCESS: begin
        if (!req_s || (m_address != addr_r) || (m_byteenable != be_r) || (m_write != write_r)) begin
          viol_s = 1'b1;
        end else begin
          viol_s = both_s;
        end
      end
      default: viol_s = both_s;
    endcase
  end

  // Transaction FSM with latched request fields and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt_r       <= '0;
      addr_r      <= '0;
      be_r        <= '0;
      wrdata_r    <= '0;
      write_r     <= 1'b0;
      rddata_r    <= '0;
      proto_err_r <= 1'b0;
      txn_r       <= '0;
    end else begin
      if (viol_s) begin
        proto_err_r <= 1'b1;
      end else begin
        proto_err_r <= proto_err_r;
      end
      case (state)
        ST_IDLE: begin
          if (start_s) begin
            addr_r   <= m_address;
            be_r     <= m_byteenable;
            wrdata_r <= m_wrdata;
            write_r  <= m_write;
            cnt_r    <= wait_load_s;
            state    <= (wait_load_s == '0) ? ST_ACCESS : ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r - WAIT_W'(1);
          if (viol_s) begin
            state <= ST_IDLE;
          end else if (cnt_r == WAIT_W'(1)) begin
            state <= ST_ACCESS;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_ACCESS: begin
          if (!write_r) begin
            rddata_r <= s_rddata;
          end else begin
            rddata_r <= rddata_r;
          end
          // The strobe of this cycle is already out; an error only skips DONE.
          state <= viol_s ? ST_IDLE : ST_DONE;
        end
        ST_DONE: begin
          txn_r <= txn_r + 32'd1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output steering: bypass passes the master straight through.
  always_comb begin
    s_address    = addr_r;
    s_byteenable = be_r;
    s_wrdata     = wrdata_r;
    s_read       = (state == ST_ACCESS) && !write_r;
    s_write      = (state == ST_ACCESS) && write_r;
    m_rddata     = rddata_r;
    m_stall      = 1'b0;
    if (bypass_s) begin
      s_address    = m_address;
      s_byteenable = m_byteenable;
      s_wrdata     = m_wrdata;
      s_read       = m_read;
      s_write      = m_write;
      m_rddata     = s_rddata;
      m_stall      = 1'b0;
    end else begin
      case (state)
        ST_IDLE:   m_stall = req_s;
        ST_WAIT:   m_stall = 1'b1;
        ST_ACCESS: m_stall = 1'b1;
        ST_DONE:   m_stall = 1'b0;
        default:   m_stall = 1'b0;
      endcase
    end
  end

  assign proto_err = proto_err_r;
  assign txn_count = txn_r;

endmodule

// File: tb/tb_bus_wait_model.sv
// Self-checking bench for bus_wait_model with a behavioural 16-word memory
// and a scoreboard of expected stall length, strobe cycle and read data.
module tb_bus_wait_model;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m_address = 32'd0;
  logic [3:0]  m_byteenable = 4'd0;
  logic        m_read = 1'b0;
  logic        m_write = 1'b0;
  logic [31:0] m_wrdata = 32'd0;
  logic [31:0] m_rddata;
  logic        m_stall;
  logic [31:0] s_address;
  logic [3:0]  s_byteenable;
  logic [31:0] s_wrdata;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_rddata;
  logic [1:0]  cfg_mode = 2'd0;
  logic [3:0]  cfg_wait = 4'd0;
  logic        proto_err;
  logic [31:0] txn_count;

  logic        mem_load = 1'b0;
  logic [31:0] mem [16];

  typedef struct {
    int          stall;
    int          strobe;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_wait_model dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_address    (m_address),
    .m_byteenable (m_byteenable),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_wrdata     (m_wrdata),
    .m_rddata     (m_rddata),
    .m_stall      (m_stall),
    .s_address    (s_address),
    .s_byteenable (s_byteenable),
    .s_wrdata     (s_wrdata),
    .s_read       (s_read),
    .s_write      (s_write),
    .s_rddata     (s_rddata),
    .cfg_mode     (cfg_mode),
    .cfg_wait     (cfg_wait),
    .proto_err    (proto_err),
    .txn_count    (txn_count)
  );

  function automatic logic [31:0] pat(input int i);
    case (i)
      1:       pat = 32'hAAAA_AAAA;
      4:       pat = 32'hDEAD_BEEF;
      default: pat = {8'hA5, i[7:0], 16'h0F0F ^ 16'(i * 13)};
    endcase
  endfunction

  assign s_rddata = mem[s_address[5:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= pat(i);
    end else if (s_write) begin
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) mem[s_address[5:2]][8*b +: 8] <= s_wrdata[8*b +: 8];
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; mem_load = 1'b1;
    m_read = 1'b0; m_write = 1'b0; m_address = 32'd0; m_byteenable = 4'd0; m_wrdata = 32'd0;
    repeat (2) @(posedge clk);
    #1; mem_load = 1'b0; rst_n = 1'b1;
  endtask

  task automatic idle;
    @(posedge clk); #1;
    m_read = 1'b0; m_write = 1'b0;
  endtask

  // Drives one request from the next cycle and measures until the stall drops.
  task automatic run_txn(input logic rd, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output int st, output int rdp,
                         output int wrp, output int stb, output logic [31:0] d, output bit to);
    st = 0; rdp = 0; wrp = 0; stb = -1; d = 32'd0; to = 1'b1;
    @(posedge clk); #1;
    m_read = rd; m_write = !rd; m_address = a; m_byteenable = be; m_wrdata = wd;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_read)  begin rdp++; stb = c; end
      if (s_write) begin wrp++; stb = c; end
      if (!m_stall) begin d = m_rddata; to = 1'b0; break; end
      st++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge clk);
    n_cmp++; if (m_stall !== 1'b0)    begin n_bad++; $display("FAIL reset_stall: got %b want 0", m_stall); end
    n_cmp++; if ({s_read, s_write} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {s_read, s_write}); end
    n_cmp++; if (m_rddata !== 32'd0)  begin n_bad++; $display("FAIL reset_rddata: got %h want 0", m_rddata); end
    n_cmp++; if (proto_err !== 1'b0)  begin n_bad++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    n_cmp++; if (txn_count !== 32'd0) begin n_bad++; $display("FAIL reset_txn_count: got %0d want 0", txn_count); end
    n_cmp++; if (s_address !== 32'd0) begin n_bad++; $display("FAIL reset_s_address: got %h want 0", s_address); end
  endtask

  task automatic test_fixed_read;
    int st, rdp, wrp, stb; logic [31:0] d; bit to; exp_t e;
    cfg_mode = 2'd0; cfg_wait = 4'd4;
    sb.push_back('{stall: 6, strobe: 5, data: 32'hDEAD_BEEF});
    run_txn(1'b1, 32'h8000_0010, 4'hF, 32'd0, st, rdp, wrp, stb, d, to);
    idle;
    e = sb.pop_front();
    n_cmp++; if (to)             begin n_bad++; $display("FAIL fixed_timeout: stall never dropped"); end
    n_cmp++; if (st !== e.stall) begin n_bad++; $display("FAIL fixed_stall: got %0d want %0d", st, e.stall); end
    n_cmp++; if (stb !== e.strobe || rdp !== 1 || wrp !== 0) begin n_bad++; $display("FAIL fixed_strobe: cycle %0d rd %0d wr %0d want cycle %0d rd 1 wr 0", stb, rdp, wrp, e.strobe); end
    n_cmp++; if (d !== e.data)   begin n_bad++; $display("FAIL fixed_rddata: got %h want %h", d, e.data); end
    n_cmp++; if (txn_count !== 32'd1) begin n_bad++; $display("FAIL fixed_txn_count: got %0d want 1", txn_count); end
  endtask

  task automatic test_zero_wait_write;
    int st, rdp, wrp, stb; logic [31:0] d; bit to; exp_t e;
    cfg_mode = 2'd0; cfg_wait = 4'd0;
    sb.push_back('{stall: 2, strobe: 1, data: 32'hAAAA_5678});
    run_txn(1'b0, 32'h0000_0004, 4'b0011, 32'h1234_5678, st, rdp, wrp, stb, d, to);
    idle;
    e = sb.pop_front();
    n_cmp++; if (to || st !== e.stall) begin n_bad++; $display("FAIL write_stall: got %0d (timeout %0d) want %0d", st, to, e.stall); end
    n_cmp++; if (stb !== e.strobe || wrp !== 1 || rdp !== 0) begin n_bad++; $display("FAIL write_strobe: cycle %0d wr %0d rd %0d want cycle %0d wr 1 rd 0", stb, wrp, rdp, e.strobe); end
    n_cmp++; if (mem[1] !== e.data) begin n_bad++; $display("FAIL write_mem: got %h want %h", mem[1], e.data); end
    n_cmp++; if (txn_count !== 32'd2) begin n_bad++; $display("FAIL write_txn_count: got %0d want 2", txn_count); end
  endtask

  task automatic test_random;
    int st, rdp, wrp, stb; logic [31:0] d; bit to; exp_t e;
    logic [15:0] l;
    logic [3:0]  w;
    int hist [2][200];
    int out_of_range = 0;
    int diffs = 0;
    for (int run = 0; run < 2; run++) begin
      do_reset;
      cfg_mode = 2'd1; cfg_wait = 4'd3;
      l = 16'hACE1;
      for (int i = 0; i < 200; i++) begin
        w = (l[3:0] < 4'd3) ? l[3:0] : 4'd3;
        sb.push_back('{stall: int'(w) + 2, strobe: int'(w) + 1, data: pat(i % 16)});
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        run_txn(1'b1, 32'(i % 16) << 2, 4'hF, 32'd0, st, rdp, wrp, stb, d, to);
        e = sb.pop_front();
        hist[run][i] = st;
        if (st < 2 || st > 5) out_of_range++;
        n_cmp++; if (to || st !== e.stall) begin n_bad++; $display("FAIL random_stall[%0d]: got %0d want %0d", i, st, e.stall); end
        n_cmp++; if (d !== e.data || stb !== e.strobe) begin n_bad++; $display("FAIL random_read[%0d]: data %h cycle %0d want %h cycle %0d", i, d, stb, e.data, e.strobe); end
      end
      idle;
      n_cmp++; if (proto_err !== 1'b0) begin n_bad++; $display("FAIL random_proto_err: got %b want 0", proto_err); end
    end
    for (int i = 0; i < 200; i++) if (hist[0][i] != hist[1][i]) diffs++;
    n_cmp++; if (out_of_range !== 0) begin n_bad++; $display("FAIL random_range: got %0d out of range want 0", out_of_range); end
    n_cmp++; if (diffs !== 0) begin n_bad++; $display("FAIL random_repeat: got %0d differences want 0", diffs); end
  endtask

  task automatic test_proto_drop;
    int seen = 0;
    do_reset;
    cfg_mode = 2'd0; cfg_wait = 4'd5;
    @(posedge clk); #1;
    m_read = 1'b1; m_address = 32'h10; m_byteenable = 4'hF;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) m_read = 1'b0;
      @(negedge clk); if (s_read) seen++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (proto_err !== 1'b1) begin n_bad++; $display("FAIL drop_proto_err: got %b want 1", proto_err); end
    n_cmp++; if (m_stall !== 1'b0)   begin n_bad++; $display("FAIL drop_idle: stall %b want 0", m_stall); end
    repeat (10) begin @(negedge clk); if (s_read) seen++; end
    n_cmp++; if (seen !== 0)          begin n_bad++; $display("FAIL drop_no_strobe: got %0d want 0", seen); end
    n_cmp++; if (proto_err !== 1'b1)  begin n_bad++; $display("FAIL drop_sticky: got %b want 1", proto_err); end
    n_cmp++; if (txn_count !== 32'd0) begin n_bad++; $display("FAIL drop_txn_count: got %0d want 0", txn_count); end
  endtask

  task automatic test_bypass;
    exp_t e;
    int stalls = 0;
    do_reset;
    cfg_mode = 2'd2; cfg_wait = 4'd7;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      m_read = 1'b1; m_address = 32'h20 + 32'(i * 4); m_byteenable = 4'hF;
      sb.push_back('{stall: 0, strobe: 0, data: pat(8 + i)});
      #1;
      e = sb.pop_front();
      if (m_stall) stalls++;
      n_cmp++; if (s_read !== 1'b1) begin n_bad++; $display("FAIL bypass_s_read_hi[%0d]: got %b want 1", i, s_read); end
      n_cmp++; if (m_rddata !== e.data) begin n_bad++; $display("FAIL bypass_rddata[%0d]: got %h want %h", i, m_rddata, e.data); end
      @(negedge clk); if (m_stall) stalls++;
      m_read = 1'b0; #1;
      n_cmp++; if (s_read !== 1'b0) begin n_bad++; $display("FAIL bypass_s_read_lo[%0d]: got %b want 0", i, s_read); end
    end
    idle;
    n_cmp++; if (stalls !== 0) begin n_bad++; $display("FAIL bypass_stall: got %0d stalled samples want 0", stalls); end
    n_cmp++; if (txn_count !== 32'd0) begin n_bad++; $display("FAIL bypass_txn_count: got %0d want 0", txn_count); end
  endtask

  task automatic test_reset_mid_write;
    int wr_seen = 0;
    do_reset;
    cfg_mode = 2'd0; cfg_wait = 4'd6;
    @(posedge clk); #1;
    m_write = 1'b1; m_address = 32'h8; m_byteenable = 4'hF; m_wrdata = 32'h5555_5555;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0; m_write = 1'b0;
    #1;
    n_cmp++; if ({s_write, s_read, m_stall} !== 3'b000) begin n_bad++; $display("FAIL rstmid_outputs: write/read/stall %b want 000", {s_write, s_read, m_stall}); end
    n_cmp++; if (s_address !== 32'd0 || s_wrdata !== 32'd0) begin n_bad++; $display("FAIL rstmid_latched: addr %h data %h want 0 0", s_address, s_wrdata); end
    n_cmp++; if (txn_count !== 32'd0 || proto_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_status: txn %0d err %b want 0 0", txn_count, proto_err); end
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (12) begin @(negedge clk); if (s_write) wr_seen++; end
    n_cmp++; if (wr_seen !== 0) begin n_bad++; $display("FAIL rstmid_no_write: got %0d pulses want 0", wr_seen); end
    n_cmp++; if (mem[2] !== pat(2)) begin n_bad++; $display("FAIL rstmid_mem: got %h want %h", mem[2], pat(2)); end
  endtask

  task automatic test_back_to_back;
    int st, rdp, wrp, stb; logic [31:0] d; bit to; exp_t e;
    do_reset;
    cfg_mode = 2'd3; cfg_wait = 4'd2;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{stall: 4, strobe: 3, data: pat(5 + i)});
      run_txn(1'b1, 32'(5 + i) << 2, 4'hF, 32'd0, st, rdp, wrp, stb, d, to);
      e = sb.pop_front();
      n_cmp++; if (to || st !== e.stall || stb !== e.strobe) begin n_bad++; $display("FAIL b2b_timing[%0d]: stall %0d cycle %0d want %0d %0d", i, st, stb, e.stall, e.strobe); end
      n_cmp++; if (d !== e.data) begin n_bad++; $display("FAIL b2b_rddata[%0d]: got %h want %h", i, d, e.data); end
    end
    idle;
    n_cmp++; if (txn_count !== 32'd3) begin n_bad++; $display("FAIL b2b_txn_count: got %0d want 3", txn_count); end
    n_cmp++; if (proto_err !== 1'b0)  begin n_bad++; $display("FAIL b2b_proto_err: got %b want 0", proto_err); end
  endtask

  initial begin
    test_reset;
    test_fixed_read;
    test_zero_wait_write;
    test_back_to_back;
    test_random;
    test_proto_drop;
    test_bypass;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
